// File: rtl/pong_pkg.sv
// pong_pkg: shared Pong geometry, ball tuning constants, ball state encoding and score helper
package pong_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int BALL_HALF = 4;
  localparam int SPEED_X = 2;
  localparam int SPEED_Y = 1;
  localparam int LEFT_PADDLE_X = 25;
  localparam int RIGHT_PADDLE_X = 615;
  localparam int PADDLE_HALF = 40;
  localparam int SERVE_FRAMES = 60;
  localparam int MAX_SCORE = 9;
  typedef enum logic [1:0] {SERVE, PLAY, POINT, GAME_OVER} state_t;
  function automatic logic [3:0] score_inc(input logic [3:0] s);
    return s == 4'(MAX_SCORE) ? s : s + 4'd1;
  endfunction
endpackage

// File: rtl/pong_paddle_hit.sv
// pong_paddle_hit: flags a ball crossing a paddle face this frame while vertically overlapping the paddle
module pong_paddle_hit
  import pong_pkg::*;
(
  input  logic [9:0]        ball_x,
  input  logic [9:0]        ball_y,
  input  logic signed [10:0] next_x,
  input  logic [9:0]        paddle_y,
  input  logic [9:0]        face,
  input  logic              left,
  input  logic              vx_neg,
  output logic              hit
);
  int bx, nx, fc, dy;
  assign bx = int'(ball_x);
  assign nx = int'(next_x);
  assign fc = int'(face);
  assign dy = int'(ball_y) - int'(paddle_y);
  assign hit = (dy <= PADDLE_HALF + BALL_HALF) && (dy >= -(PADDLE_HALF + BALL_HALF)) &&
               (left ? vx_neg && (bx - BALL_HALF > fc) && (nx - BALL_HALF <= fc)
                     : !vx_neg && (bx + BALL_HALF < fc) && (nx + BALL_HALF >= fc));
endmodule

// File: rtl/pong_ball.sv
// pong_ball: per-frame ball engine owning position, velocity, scores and serve/point/game-over sequencing
module pong_ball
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frameTick,
  input  logic [9:0] leftPaddleY,
  input  logic [9:0] rightPaddleY,
  output logic [9:0] ballX,
  output logic [9:0] ballY,
  output logic [3:0] leftScore,
  output logic [3:0] rightScore,
  output logic       pointScored,
  output logic       gameOver
);
  state_t state;
  logic [5:0] serve_cnt;
  logic vx_neg, vy_neg, left_won, hit_l, hit_r, left_pt, right_pt, top, bot, pvx_neg, pvy_neg;
  logic [9:0] px, py;
  logic [3:0] ns;
  int nx, ny;
  always_comb begin
    nx = int'(ballX) + (vx_neg ? -SPEED_X : SPEED_X);
    ny = int'(ballY) + (vy_neg ? -SPEED_Y : SPEED_Y);
    right_pt = nx - BALL_HALF <= 0;
    left_pt = nx + BALL_HALF >= SCREEN_W - 1;
    top = ny - BALL_HALF <= 0;
    bot = ny + BALL_HALF >= SCREEN_H - 1;
    py = 10'(top ? BALL_HALF : bot ? SCREEN_H - 1 - BALL_HALF : ny);
    pvy_neg = top ? 1'b0 : bot ? 1'b1 : vy_neg;
    px = 10'(hit_l ? LEFT_PADDLE_X + 2 + BALL_HALF : hit_r ? RIGHT_PADDLE_X - 2 - BALL_HALF : nx);
    pvx_neg = hit_l ? 1'b0 : hit_r ? 1'b1 : vx_neg;
    ns = score_inc(left_won ? leftScore : rightScore);
  end
  pong_paddle_hit u_hit_l (
    .ball_x(ballX), .ball_y(ballY), .next_x(11'(nx)), .paddle_y(leftPaddleY),
    .face(10'(LEFT_PADDLE_X + 1)), .left(1'b1), .vx_neg(vx_neg), .hit(hit_l)
  );
  pong_paddle_hit u_hit_r (
    .ball_x(ballX), .ball_y(ballY), .next_x(11'(nx)), .paddle_y(rightPaddleY),
    .face(10'(RIGHT_PADDLE_X - 1)), .left(1'b0), .vx_neg(vx_neg), .hit(hit_r)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= SERVE;
      serve_cnt <= '0;
      ballX <= 10'(SCREEN_W / 2);
      ballY <= 10'(SCREEN_H / 2);
      vx_neg <= 1'b0;
      vy_neg <= 1'b0;
      left_won <= 1'b0;
      leftScore <= '0;
      rightScore <= '0;
      pointScored <= 1'b0;
      gameOver <= 1'b0;
    end else begin
      pointScored <= 1'b0;
      if (frameTick)
        case (state)
          SERVE: begin
            serve_cnt <= serve_cnt == 6'(SERVE_FRAMES - 1) ? '0 : serve_cnt + 6'd1;
            if (serve_cnt == 6'(SERVE_FRAMES - 1)) state <= PLAY;
          end
          PLAY:
            if (left_pt || right_pt) begin
              state <= POINT;
              left_won <= left_pt;
            end else begin
              ballX <= px;
              ballY <= py;
              vx_neg <= pvx_neg;
              vy_neg <= pvy_neg;
            end
          POINT: begin
            pointScored <= 1'b1;
            ballX <= 10'(SCREEN_W / 2);
            ballY <= 10'(SCREEN_H / 2);
            vx_neg <= !left_won;
            vy_neg <= !vy_neg;
            if (left_won) leftScore <= ns;
            else rightScore <= ns;
            state <= ns == 4'(MAX_SCORE) ? GAME_OVER : SERVE;
            gameOver <= ns == 4'(MAX_SCORE);
          end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_pong_ball.sv
// tb_pong_ball: directed self-checking bench for pong_ball with hand-traced ball trajectories
module tb_pong_ball;
  logic clk = 1'b0, rst_n = 1'b0, frame_tick = 1'b0;
  logic [9:0] lpy = 10'd100, rpy = 10'd340, ball_x, ball_y;
  logic [3:0] l_score, r_score;
  logic point_scored, game_over;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  pong_ball dut (
    .clk(clk), .rst_n(rst_n), .frameTick(frame_tick), .leftPaddleY(lpy), .rightPaddleY(rpy),
    .ballX(ball_x), .ballY(ball_y), .leftScore(l_score), .rightScore(r_score),
    .pointScored(point_scored), .gameOver(game_over)
  );
  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic ticks(input int n);
    repeat (n) begin
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
    end
  endtask
  task automatic pos(input string tag, input int x, input int y);
    check({tag, "_x"}, int'(ball_x), x);
    check({tag, "_y"}, int'(ball_y), y);
  endtask
  task automatic run_to_point();
    int n = 0;
    @(negedge clk);
    while (!point_scored && n < 400) begin
      ticks(1);
      n++;
    end
    check("point_seen", int'(point_scored), 1);
  endtask
  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask
  initial begin
    do_reset();
    pos("rst", 320, 240);
    check("rst_ls", int'(l_score), 0);
    check("rst_rs", int'(r_score), 0);
    check("rst_pt", int'(point_scored), 0);
    check("rst_go", int'(game_over), 0);
    ticks(59); pos("serve59", 320, 240);
    ticks(1); pos("serve60", 320, 240);
    ticks(1); pos("play1", 322, 241);
    repeat (5) @(negedge clk);
    pos("hold", 322, 241);
    ticks(143); pos("k144", 608, 384);
    ticks(1); pos("rhit_edge", 609, 385);
    ticks(1); pos("k146", 607, 386);
    ticks(88); pos("k234", 431, 474);
    ticks(1); pos("bot", 429, 475);
    ticks(1); pos("bot_after", 427, 474);
    ticks(211); pos("k447", 5, 263);
    ticks(1); pos("miss_frozen", 5, 263);
    check("miss_pt", int'(point_scored), 0);
    check("miss_rs", int'(r_score), 0);
    ticks(1); pos("point1", 320, 240);
    check("point1_rs", int'(r_score), 1);
    check("point1_ls", int'(l_score), 0);
    check("point1_pt", int'(point_scored), 1);
    @(negedge clk) check("point1_pt_off", int'(point_scored), 0);
    lpy = 10'd428; rpy = 10'd231;
    ticks(60); pos("serve2", 320, 240);
    ticks(1); pos("p2k1", 318, 241);
    ticks(143); pos("p2k144", 32, 384);
    ticks(1); pos("lhit_edge", 31, 385);
    ticks(1); pos("p2k146", 33, 386);
    ticks(89); pos("p2bot", 211, 475);
    ticks(200); pos("rmiss_by1", 611, 275);
    ticks(11); pos("p2k446", 633, 264);
    ticks(1); pos("p2frozen", 633, 264);
    ticks(1); pos("point2", 320, 240);
    check("point2_ls", int'(l_score), 1);
    check("point2_rs", int'(r_score), 1);
    lpy = 10'd276; rpy = 10'd384;
    ticks(60);
    ticks(145); pos("p3rhit", 609, 385);
    ticks(290); pos("p3lhit", 31, 275);
    ticks(270); pos("p3k705", 571, 5);
    ticks(1); pos("top", 573, 4);
    ticks(1); pos("top_after", 575, 5);
    run_to_point();
    check("point3_ls", int'(l_score), 2);
    lpy = 10'd1023; rpy = 10'd1023;
    for (int i = 3; i <= 8; i++) begin
      run_to_point();
      check("loop_ls", int'(l_score), i);
      check("loop_go", int'(game_over), 0);
    end
    run_to_point();
    check("final_ls", int'(l_score), 9);
    check("final_rs", int'(r_score), 1);
    check("final_go", int'(game_over), 1);
    ticks(100);
    pos("go_idle", 320, 240);
    check("go_idle_ls", int'(l_score), 9);
    check("go_idle_go", int'(game_over), 1);
    check("go_idle_pt", int'(point_scored), 0);
    do_reset();
    pos("rst2", 320, 240);
    check("rst2_ls", int'(l_score), 0);
    check("rst2_rs", int'(r_score), 0);
    check("rst2_go", int'(game_over), 0);
    ticks(61); pos("p5k1", 322, 241);
    @(negedge clk) begin rst_n = 1'b0; frame_tick = 1'b1; end
    @(negedge clk) begin rst_n = 1'b1; frame_tick = 1'b0; end
    pos("rst_tick", 320, 240);
    ticks(60); pos("rst_serve60", 320, 240);
    ticks(1); pos("rst_play1", 322, 241);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
